// File: rtl/fir_pkg.sv
// Shared types and sizing for the FIR coefficient controller.
// Tap count and width are fixed here for the 31-tap systolic FIR.
package fir_pkg;
  localparam int C_W       = 12;
  localparam int C_NUM     = 31;
  localparam int AW        = $clog2(C_NUM);
  localparam int FLUSH_CYC = C_NUM + 1;
  localparam int FW        = $clog2(FLUSH_CYC + 1);

  typedef logic signed [C_W-1:0] coeff_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    READY,
    FLUSH
  } ctrl_state_t;
endpackage

// File: rtl/fir_coeff_ctrl_if.sv
// Coefficient stream handshake between the config side
// and the coefficient controller.
interface fir_coeff_ctrl_if;
  import fir_pkg::*;

  logic   cfg_valid;
  logic   cfg_ready;
  logic   cfg_last;
  coeff_t cfg_data;

  modport master (
    output cfg_valid,
    output cfg_data,
    output cfg_last,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_data,
    input  cfg_last,
    output cfg_ready
  );
endinterface

// File: rtl/fir_coeff_bank.sv
// Two-bank coefficient store: one write port, full-width
// read of the active bank for the MAC array.
module fir_coeff_bank
  import fir_pkg::*;
(
  input  logic                 clock,
  input  logic                 wr_en,
  input  logic                 wr_bank,
  input  logic [AW-1:0]        wr_addr,
  input  coeff_t               wr_data,
  input  logic                 bank_sel,
  output logic [C_NUM*C_W-1:0] taps
);
  coeff_t mem [2][C_NUM];

  always_ff @(posedge clock) begin
    if (wr_en && int'(wr_addr) < C_NUM)
      mem[wr_bank][wr_addr] <= wr_data;
  end

  for (genvar i = 0; i < C_NUM; i++) begin : g_rd
    assign taps[i*C_W +: C_W] = mem[bank_sel][i];
  end
endmodule

// File: rtl/fir_coeff_ctrl.sv
// Coefficient load / bank-swap controller for the systolic FIR.
// Define FIR_COEFF_SYM_EN for half-length symmetric loads.
module fir_coeff_ctrl
  import fir_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  fir_coeff_ctrl_if.slave      cfg,
  input  logic                 commit,
  output logic                 coeff_wr_en,
  output logic                 coeff_wr_bank,
  output logic [AW-1:0]        coeff_wr_addr,
  output coeff_t               coeff_wr_data,
  output logic                 bank_sel,
  output logic                 fir_out_valid,
  output logic                 load_done,
  output logic                 swap_done,
  output logic                 err_len,
  output logic [C_NUM*C_W-1:0] taps
);
`ifdef FIR_COEFF_SYM_EN
  localparam int LEN = (C_NUM + 1) / 2;
`else
  localparam int LEN = C_NUM;
`endif
  localparam logic [AW-1:0] LAST_A = AW'(LEN - 1);
  localparam logic [AW-1:0] TOP_A  = AW'(C_NUM - 1);

  ctrl_state_t   state, state_n;
  logic [AW-1:0] cnt, cnt_n;
  logic [FW-1:0] fcnt, fcnt_n;
  logic          bank_n, ld_n, sw_n, err_n;
  logic          acc, in_ld, mir;
  logic [AW-1:0] wa;
  coeff_t        wd;

  assign in_ld = (state == IDLE) || (state == LOAD);
  assign cfg.cfg_ready =
    !((state == READY) || (state == FLUSH) || mir);
  assign acc = cfg.cfg_valid && cfg.cfg_ready;
  assign fir_out_valid = (state != FLUSH);

`ifdef FIR_COEFF_SYM_EN
  logic          mir_set;
  logic [AW-1:0] mir_addr;
  coeff_t        mir_data;

  // Mirror only words that continue a valid load; centre tap is written once.
  assign mir_set = acc && in_ld &&
    (cfg.cfg_last == (cnt == LAST_A)) &&
    ((TOP_A - cnt) != cnt);

  always_ff @(posedge clock) begin
    if (reset) begin
      mir      <= 1'b0;
      mir_addr <= '0;
      mir_data <= '0;
    end else begin
      mir <= mir_set;
      if (mir_set) begin
        mir_addr <= TOP_A - cnt;
        mir_data <= cfg.cfg_data;
      end
    end
  end

  assign wa = mir ? mir_addr : cnt;
  assign wd = mir ? mir_data : cfg.cfg_data;
`else
  assign mir = 1'b0;
  assign wa  = cnt;
  assign wd  = cfg.cfg_data;
`endif

  assign coeff_wr_en   = (acc && in_ld) || mir;
  assign coeff_wr_bank = coeff_wr_en & ~bank_sel;
  assign coeff_wr_addr = coeff_wr_en ? wa : '0;
  assign coeff_wr_data = coeff_wr_en ? wd : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      fcnt      <= '0;
      bank_sel  <= 1'b0;
      load_done <= 1'b0;
      swap_done <= 1'b0;
      err_len   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      fcnt      <= fcnt_n;
      bank_sel  <= bank_n;
      load_done <= ld_n;
      swap_done <= sw_n;
      err_len   <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    fcnt_n  = fcnt;
    bank_n  = bank_sel;
    ld_n    = 1'b0;
    sw_n    = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      IDLE, LOAD: begin
        if (acc) begin
          if (cfg.cfg_last && cnt == LAST_A) begin
            ld_n    = 1'b1;
            cnt_n   = '0;
            state_n = READY;
          end else if (cfg.cfg_last) begin
            err_n   = 1'b1;
            cnt_n   = '0;
            state_n = IDLE;
          end else if (cnt == LAST_A) begin
            err_n   = 1'b1;
            cnt_n   = '0;
            state_n = DRAIN;
          end else begin
            cnt_n   = cnt + AW'(1);
            state_n = LOAD;
          end
        end
      end
      DRAIN: begin
        if (acc && cfg.cfg_last)
          state_n = IDLE;
      end
      READY: begin
        if (commit && !mir) begin
          bank_n  = ~bank_sel;
          sw_n    = 1'b1;
          fcnt_n  = FW'(FLUSH_CYC);
          state_n = FLUSH;
        end
      end
      FLUSH: begin
        if (fcnt == FW'(1)) begin
          fcnt_n  = '0;
          state_n = IDLE;
        end else begin
          fcnt_n = fcnt - FW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  fir_coeff_bank u_bank (
    .clock    (clock),
    .wr_en    (coeff_wr_en),
    .wr_bank  (coeff_wr_bank),
    .wr_addr  (coeff_wr_addr),
    .wr_data  (coeff_wr_data),
    .bank_sel (bank_sel),
    .taps     (taps)
  );
endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Directed bench for fir_coeff_ctrl: loads, length errors,
// stalls, commit/flush timing and reset during a load.
module tb_fir_coeff_ctrl;
  import fir_pkg::*;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 commit;
  logic                 coeff_wr_en;
  logic                 coeff_wr_bank;
  logic [AW-1:0]        coeff_wr_addr;
  coeff_t               coeff_wr_data;
  logic                 bank_sel;
  logic                 fir_out_valid;
  logic                 load_done;
  logic                 swap_done;
  logic                 err_len;
  logic [C_NUM*C_W-1:0] taps;

  fir_coeff_ctrl_if cfg();

  fir_coeff_ctrl dut (
    .clock         (clock),
    .reset         (reset),
    .cfg           (cfg.slave),
    .commit        (commit),
    .coeff_wr_en   (coeff_wr_en),
    .coeff_wr_bank (coeff_wr_bank),
    .coeff_wr_addr (coeff_wr_addr),
    .coeff_wr_data (coeff_wr_data),
    .bank_sel      (bank_sel),
    .fir_out_valid (fir_out_valid),
    .load_done     (load_done),
    .swap_done     (swap_done),
    .err_len       (err_len),
    .taps          (taps)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int tot_ld = 0;
  int tot_sw = 0;
  int tot_err = 0;
  int tot_stall = 0;
  logic [AW-1:0] wa [$];
  coeff_t        wd [$];
  logic          wb [$];
  coeff_t        exp_taps [C_NUM];

  always @(negedge clock) begin
    if (coeff_wr_en) begin
      wa.push_back(coeff_wr_addr);
      wd.push_back(coeff_wr_data);
      wb.push_back(coeff_wr_bank);
    end
    if (load_done) tot_ld++;
    if (swap_done) tot_sw++;
    if (err_len) tot_err++;
    if (cfg.cfg_valid && !cfg.cfg_ready) tot_stall++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input coeff_t d, input logic last);
    int t;
    bit ok;
    t = 0;
    ok = 1'b0;
    cfg.cfg_valid = 1'b1;
    cfg.cfg_data  = d;
    cfg.cfg_last  = last;
    while (!ok && t < 8) begin
      ok = cfg.cfg_ready;
      tick();
      t++;
    end
    cfg.cfg_valid = 1'b0;
    cfg.cfg_last  = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout got ready=0 for %0d cycles want accept", t);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    commit = 1'b0;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_last = 1'b0;
    cfg.cfg_data = '0;
    tick();
    tick();
    checks++;
    if (cfg.cfg_ready !== 1'b1) begin
      errors++; $display("FAIL rst_ready got %b want 1", cfg.cfg_ready);
    end
    checks++;
    if (fir_out_valid !== 1'b1) begin
      errors++; $display("FAIL rst_fov got %b want 1", fir_out_valid);
    end
    checks++;
    if ({bank_sel, load_done, swap_done, err_len} !== 4'b0) begin
      errors++;
      $display("FAIL rst_flags got %b want 0000",
        {bank_sel, load_done, swap_done, err_len});
    end
    checks++;
    if ({coeff_wr_en, coeff_wr_bank} !== 2'b0 || coeff_wr_addr !== '0) begin
      errors++;
      $display("FAIL rst_wr got en=%b bank=%b addr=%0d want 0",
        coeff_wr_en, coeff_wr_bank, coeff_wr_addr);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_full();
    int b, bad;
    b = wa.size();
    bad = 0;
    for (int i = 0; i < C_NUM; i++)
      send(coeff_t'(i + 1), i == C_NUM - 1);
    checks++;
    if (load_done !== 1'b1) begin
      errors++; $display("FAIL full_load_done got %b want 1", load_done);
    end
    checks++;
    if (bank_sel !== 1'b0) begin
      errors++; $display("FAIL full_bank_sel got %b want 0", bank_sel);
    end
    checks++;
    if (cfg.cfg_ready !== 1'b0) begin
      errors++; $display("FAIL full_ready_hold got %b want 0", cfg.cfg_ready);
    end
    for (int i = 0; i < C_NUM; i++) begin
      exp_taps[i] = coeff_t'(i + 1);
      if (b + i >= wa.size() || wa[b+i] !== AW'(i) ||
          wd[b+i] !== coeff_t'(i + 1) || wb[b+i] !== 1'b1)
        bad++;
    end
    checks++;
    if (wa.size() - b != C_NUM || bad != 0) begin
      errors++;
      $display("FAIL full_writes got n=%0d bad=%0d want n=%0d bad=0",
        wa.size() - b, bad, C_NUM);
    end
  endtask

`ifdef FIR_COEFF_SYM_EN
  task automatic test_sym();
    int b, st0, bad;
    logic [AW-1:0] ea [$];
    coeff_t        ed [$];
    localparam int H = (C_NUM + 1) / 2;
    b = wa.size();
    st0 = tot_stall;
    bad = 0;
    for (int k = 0; k < H; k++) begin
      send(coeff_t'(32'h100 + k), k == H - 1);
      ea.push_back(AW'(k));
      ed.push_back(coeff_t'(32'h100 + k));
      exp_taps[k] = coeff_t'(32'h100 + k);
      exp_taps[C_NUM-1-k] = coeff_t'(32'h100 + k);
      if (C_NUM - 1 - k != k) begin
        ea.push_back(AW'(C_NUM - 1 - k));
        ed.push_back(coeff_t'(32'h100 + k));
      end
    end
    checks++;
    if (load_done !== 1'b1) begin
      errors++; $display("FAIL sym_load_done got %b want 1", load_done);
    end
    checks++;
    if (tot_stall - st0 != H - 1) begin
      errors++;
      $display("FAIL sym_mirror_stalls got %0d want %0d", tot_stall - st0, H - 1);
    end
    for (int i = 0; i < ea.size(); i++)
      if (b + i >= wa.size() || wa[b+i] !== ea[i] ||
          wd[b+i] !== ed[i] || wb[b+i] !== 1'b1)
        bad++;
    checks++;
    if (wa.size() - b != ea.size() || bad != 0) begin
      errors++;
      $display("FAIL sym_writes got n=%0d bad=%0d want n=%0d bad=0",
        wa.size() - b, bad, ea.size());
    end
  endtask
`endif

  task automatic test_commit();
    logic b0;
    int s0, n, bad;
    b0 = bank_sel;
    s0 = tot_sw;
    n = 0;
    bad = 0;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    checks++;
    if (bank_sel !== ~b0 || swap_done !== 1'b1) begin
      errors++;
      $display("FAIL commit_swap got bank=%b swap=%b want bank=%b swap=1",
        bank_sel, swap_done, ~b0);
    end
    while (!fir_out_valid && n < 100) begin
      n++;
      tick();
    end
    checks++;
    if (n != FLUSH_CYC) begin
      errors++; $display("FAIL flush_len got %0d want %0d", n, FLUSH_CYC);
    end
    checks++;
    if (tot_sw - s0 != 1) begin
      errors++; $display("FAIL swap_pulses got %0d want 1", tot_sw - s0);
    end
    for (int i = 0; i < C_NUM; i++)
      if (taps[i*C_W +: C_W] !== exp_taps[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL active_taps got %0d wrong want 0", bad);
    end
    checks++;
    if (cfg.cfg_ready !== 1'b1) begin
      errors++; $display("FAIL post_flush_ready got %b want 1", cfg.cfg_ready);
    end
  endtask

  task automatic test_reset_mid();
    int e0;
    e0 = tot_err;
    for (int i = 0; i < 5; i++)
      send(coeff_t'(32'h50 + i), 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (bank_sel !== 1'b0 || cfg.cfg_ready !== 1'b1 || fir_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_state got bank=%b ready=%b fov=%b want 0 1 1",
        bank_sel, cfg.cfg_ready, fir_out_valid);
    end
    tick();
    checks++;
    if (tot_err - e0 != 0) begin
      errors++; $display("FAIL midrst_err got %0d want 0", tot_err - e0);
    end
  endtask

  task automatic test_short();
    int b, e0, l0, s0;
    logic b0;
    b = wa.size();
    e0 = tot_err;
    l0 = tot_ld;
    s0 = tot_sw;
    b0 = bank_sel;
    send(coeff_t'(32'h0AB), 1'b1);
    checks++;
    if (err_len !== 1'b1 || cfg.cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_last got err=%b ready=%b want 1 1",
        err_len, cfg.cfg_ready);
    end
    for (int i = 0; i < 10; i++)
      send(coeff_t'(32'h200 + i), i == 9);
    checks++;
    if (err_len !== 1'b1 || cfg.cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL short_err got err=%b ready=%b want 1 1",
        err_len, cfg.cfg_ready);
    end
    commit = 1'b1;
    tick();
    commit = 1'b0;
    tick();
    checks++;
    if (bank_sel !== b0 || tot_sw - s0 != 0) begin
      errors++;
      $display("FAIL short_commit got bank=%b swaps=%0d want %b 0",
        bank_sel, tot_sw - s0, b0);
    end
    checks++;
    if (tot_err - e0 != 2 || tot_ld - l0 != 0 || wa.size() - b != 11) begin
      errors++;
      $display("FAIL short_counts got err=%0d ld=%0d wr=%0d want 2 0 11",
        tot_err - e0, tot_ld - l0, wa.size() - b);
    end
  endtask

  task automatic test_long();
    int b, e0, l0, bad;
    b = wa.size();
    e0 = tot_err;
    l0 = tot_ld;
    bad = 0;
    for (int i = 0; i < 35; i++) begin
      send(coeff_t'(32'h400 + i), i == 34);
      if (i == C_NUM - 1) begin
        checks++;
        if (err_len !== 1'b1) begin
          errors++; $display("FAIL long_err_at_31 got %b want 1", err_len);
        end
      end
    end
    tick();
    for (int i = 0; i < C_NUM; i++)
      if (b + i >= wa.size() || wa[b+i] !== AW'(i) ||
          wd[b+i] !== coeff_t'(32'h400 + i))
        bad++;
    checks++;
    if (wa.size() - b != C_NUM || bad != 0) begin
      errors++;
      $display("FAIL long_writes got n=%0d bad=%0d want n=%0d bad=0",
        wa.size() - b, bad, C_NUM);
    end
    checks++;
    if (tot_err - e0 != 1 || tot_ld - l0 != 0 || cfg.cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL long_end got err=%0d ld=%0d ready=%b want 1 0 1",
        tot_err - e0, tot_ld - l0, cfg.cfg_ready);
    end
  endtask

  task automatic test_back_to_back();
    int b, s0, i, cyc, bad, wr_stall;
    logic b0;
    b = wa.size();
    s0 = tot_sw;
    b0 = bank_sel;
    i = 0;
    cyc = 0;
    bad = 0;
    wr_stall = 0;
    while (i < C_NUM && cyc < 200) begin
      cfg.cfg_valid = (cyc % 2 == 0);
      cfg.cfg_data  = coeff_t'(32'h300 + i);
      cfg.cfg_last  = (i == C_NUM - 1);
      commit        = (cyc == 6);
      #1;
      if (!cfg.cfg_valid && coeff_wr_en) wr_stall++;
      if (cfg.cfg_valid && cfg.cfg_ready) i++;
      tick();
      cyc++;
    end
    cfg.cfg_valid = 1'b0;
    cfg.cfg_last  = 1'b0;
    commit        = 1'b0;
    checks++;
    if (i != C_NUM || load_done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done got words=%0d ld=%b want %0d 1",
        i, load_done, C_NUM);
    end
    checks++;
    if (bank_sel !== b0 || tot_sw - s0 != 0) begin
      errors++;
      $display("FAIL b2b_commit_ignored got bank=%b swaps=%0d want %b 0",
        bank_sel, tot_sw - s0, b0);
    end
    for (int k = 0; k < C_NUM; k++) begin
      exp_taps[k] = coeff_t'(32'h300 + k);
      if (b + k >= wa.size() || wa[b+k] !== AW'(k) ||
          wd[b+k] !== coeff_t'(32'h300 + k) || wb[b+k] !== ~b0)
        bad++;
    end
    checks++;
    if (wa.size() - b != C_NUM || bad != 0 || wr_stall != 0) begin
      errors++;
      $display("FAIL b2b_writes got n=%0d bad=%0d stallwr=%0d want %0d 0 0",
        wa.size() - b, bad, wr_stall, C_NUM);
    end
  endtask

  initial begin
    test_reset();
`ifdef FIR_COEFF_SYM_EN
    test_sym();
    test_commit();
    test_reset_mid();
    test_short();
`else
    test_full();
    test_commit();
    test_reset_mid();
    test_short();
    test_long();
    test_back_to_back();
    test_commit();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish before 200000");
    $fatal(1);
  end
endmodule
